// File: rtl/config_chain_loader.sv
// Serial configuration chain loader: streams CHAIN_LENGTH bits from host words into the
// chain head, MSB first, while capturing the chain tail into readback words.
module config_chain_loader #(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 36,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                  config_clock,
    input  logic                  config_nreset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data,
    output logic                  chain_enable,
    input  logic                  chain_return,
    output logic [WORD_WIDTH-1:0] readback_word,
    output logic                  readback_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE_C        = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] WORD_BITS_C  = COUNT_WIDTH'(WORD_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CHAIN_BITS_C = COUNT_WIDTH'(CHAIN_LENGTH);

    state_t                 state_q;
    logic [WORD_WIDTH-1:0]  shreg_q;
    logic [WORD_WIDTH-1:0]  rb_shreg_q;
    logic [WORD_WIDTH-1:0]  rb_word_q;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic [COUNT_WIDTH-1:0] word_bits_q;
    logic [COUNT_WIDTH-1:0] rb_count_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   rb_valid_q;

    logic [WORD_WIDTH-1:0]  rb_shreg_d;
    logic [WORD_WIDTH-1:0]  rb_flush_d;
    logic [COUNT_WIDTH-1:0] rb_count_d;
    logic [COUNT_WIDTH-1:0] remaining_d;
    logic [COUNT_WIDTH-1:0] word_bits_d;
    logic [COUNT_WIDTH-1:0] load_bits_d;

    assign rb_shreg_d  = {rb_shreg_q[WORD_WIDTH-2:0], chain_return};
    assign rb_count_d  = rb_count_q + ONE_C;
    // Final partial readback word is left-aligned, so the first bit out sits in the MSB.
    assign rb_flush_d  = rb_shreg_d << (WORD_BITS_C - rb_count_d);
    assign remaining_d = remaining_q - ONE_C;
    assign word_bits_d = word_bits_q - ONE_C;
    assign load_bits_d = (remaining_q < WORD_BITS_C) ? remaining_q : WORD_BITS_C;

    always_ff @(posedge config_clock or negedge config_nreset) begin
        if (!config_nreset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            rb_shreg_q  <= '0;
            rb_word_q   <= '0;
            remaining_q <= '0;
            word_bits_q <= '0;
            rb_count_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rb_valid_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rb_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        remaining_q <= CHAIN_BITS_C;
                        rb_count_q  <= '0;
                        rb_shreg_q  <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (word_valid) begin
                        shreg_q     <= word_in;
                        word_bits_q <= load_bits_d;
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q     <= shreg_q << 1;
                    remaining_q <= remaining_d;
                    word_bits_q <= word_bits_d;
                    rb_shreg_q  <= rb_shreg_d;
                    // The tiles still shift on an aborting edge; only our bookkeeping stops.
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        if (rb_count_d == WORD_BITS_C) begin
                            rb_word_q  <= rb_shreg_d;
                            rb_valid_q <= 1'b1;
                            rb_count_q <= '0;
                        end else begin
                            rb_count_q <= rb_count_d;
                        end
                        if (word_bits_q == ONE_C) begin
                            if (remaining_q == ONE_C) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                                if (rb_count_d != WORD_BITS_C) begin
                                    rb_word_q  <= rb_flush_d;
                                    rb_valid_q <= 1'b1;
                                end
                            end else begin
                                state_q <= S_LOAD;
                            end
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready     = (state_q == S_LOAD);
    assign chain_enable   = (state_q == S_SHIFT);
    assign chain_data     = (state_q == S_SHIFT) & shreg_q[WORD_WIDTH-1];
    assign readback_word  = rb_word_q;
    assign readback_valid = rb_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader: a bit-level chain model supplies chain_return,
// and expected streams/readbacks are derived from the host words and the chain image.
module tb_config_chain_loader;

    localparam int W  = 32;
    localparam int L  = 36;
    localparam int CW = 16;
    localparam int NW = (L + W - 1) / W;

    logic          config_clock = 1'b0;
    logic          config_nreset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic          chain_data;
    logic          chain_enable;
    logic          chain_return;
    logic [W-1:0]  readback_word;
    logic          readback_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [L-1:0]  chain_m;
    logic [W-1:0]  words [NW];
    logic [L-1:0]  last_sent;
    logic [W-1:0]  last_rb [$];

    config_chain_loader #(
        .WORD_WIDTH  (W),
        .CHAIN_LENGTH(L),
        .COUNT_WIDTH (CW)
    ) dut (
        .config_clock  (config_clock),
        .config_nreset (config_nreset),
        .start         (start),
        .abort         (abort),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .chain_data    (chain_data),
        .chain_enable  (chain_enable),
        .chain_return  (chain_return),
        .readback_word (readback_word),
        .readback_valid(readback_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 config_clock = ~config_clock;

    // Chain of tile config registers: bit 0 is the head, bit L-1 the tail.
    assign chain_return = chain_m[L-1];
    always @(posedge config_clock or negedge config_nreset) begin
        if (!config_nreset) chain_m <= '0;
        else if (chain_enable) chain_m <= {chain_m[L-2:0], chain_data};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_load(input string name, input int gap_len, input bit poke_start,
                            input int abort_after, input bit start_with_abort);
        logic [L-1:0] exp_sent;
        logic [L-1:0] act_sent;
        logic [L-1:0] old_img;
        logic [W-1:0] exp_rb [$];
        logic [W-1:0] act_rb [$];
        logic [W-1:0] w;
        int n_en = 0, n_ready = 0, n_done = 0, idx = 0, waited = 0, cyc = 0, tail = -1;
        bit finished = 0, abort_pending = 0, aborted = 0;

        old_img  = chain_m;
        act_sent = '0;
        for (int i = 0; i < L; i++) exp_sent[L-1-i] = words[i/W][W-1-(i%W)];
        for (int k = 0; k < NW; k++) begin
            w = '0;
            for (int j = 0; j < W; j++)
                if (k*W + j < L) w[W-1-j] = old_img[L-1-(k*W+j)];
            exp_rb.push_back(w);
        end

        @(negedge config_clock);
        start = 1'b1;
        abort = start_with_abort;
        @(negedge config_clock);
        start = 1'b0;
        abort = 1'b0;

        while (!finished && cyc < 400) begin
            if (abort_pending) begin
                check({name, "_abort_enable"}, 64'(chain_enable), 64'(0));
                check({name, "_abort_busy"}, 64'(busy), 64'(0));
                abort_pending = 0;
            end
            if (chain_enable) begin
                if (n_en < L) act_sent[L-1-n_en] = chain_data;
                n_en++;
            end
            if (word_ready) n_ready++;
            if (readback_valid) act_rb.push_back(readback_word);
            if (done) begin
                n_done++;
                if (tail < 0) tail = 3;
            end

            start = 1'b0;
            abort = 1'b0;
            if (word_ready && idx < NW) begin
                if (idx == 1 && waited < gap_len) begin
                    word_valid = 1'b0;
                    waited++;
                end else begin
                    word_valid = 1'b1;
                    word_in    = words[idx];
                    idx++;
                end
            end else begin
                word_valid = 1'b0;
                word_in    = W'($urandom);
            end
            if (poke_start && chain_enable && n_en == 5) start = 1'b1;
            if (abort_after > 0 && chain_enable && n_en == abort_after && !aborted) begin
                abort         = 1'b1;
                aborted       = 1;
                abort_pending = 1;
                tail          = 6;
            end

            if (tail > 0) tail--;
            if (tail == 0) finished = 1;
            @(negedge config_clock);
            cyc++;
        end
        word_valid = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;

        check({name, "_finished"}, 64'(finished), 64'(1));
        check({name, "_busy_end"}, 64'(busy), 64'(0));
        if (aborted) begin
            check({name, "_enables"}, 64'(n_en), 64'(abort_after));
            check({name, "_prefix"}, 64'(act_sent >> (L - abort_after)),
                  64'(exp_sent >> (L - abort_after)));
            check({name, "_no_done"}, 64'(n_done), 64'(0));
            check({name, "_no_readback"}, 64'(act_rb.size()), 64'(0));
        end else begin
            check({name, "_enables"}, 64'(n_en), 64'(L));
            check({name, "_stream"}, 64'(act_sent), 64'(exp_sent));
            check({name, "_load_cycles"}, 64'(n_ready), 64'(NW + gap_len));
            check({name, "_done_pulses"}, 64'(n_done), 64'(1));
            check({name, "_rb_count"}, 64'(act_rb.size()), 64'(NW));
            for (int k = 0; k < NW && k < act_rb.size(); k++)
                check({name, "_rb_word"}, 64'(act_rb[k]), 64'(exp_rb[k]));
        end
        last_sent = act_sent;
        last_rb   = act_rb;
        $display("load %s: enables=%0d load_cycles=%0d done=%0d readbacks=%0d", name, n_en,
                 n_ready, n_done, act_rb.size());
    endtask

    task automatic set_fixed_words();
        words[0] = 32'hA5A50F0F;
        words[1] = 32'hC0000000;
    endtask

    task automatic set_random_words();
        for (int k = 0; k < NW; k++) words[k] = W'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge config_clock);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ready", 64'(word_ready), 64'(0));
        check("reset_enable", 64'(chain_enable), 64'(0));
        check("reset_rb", 64'({readback_valid, done, chain_data, readback_word}), 64'(0));
        config_nreset = 1'b1;
        repeat (2) @(negedge config_clock);
        check("idle_ready", 64'(word_ready), 64'(0));

        set_fixed_words();
        run_load("fixed1", 0, 1'b0, 0, 1'b0);
        check("fixed1_seq", 64'(last_sent), 64'h0A5A50F0FC);

        run_load("fixed2", 0, 1'b0, 0, 1'b0);
        check("fixed2_rb0", 64'(last_rb.size() > 0 ? last_rb[0] : '0), 64'hA5A50F0F);
        check("fixed2_rb1", 64'(last_rb.size() > 1 ? last_rb[1] : '0), 64'hC0000000);

        run_load("gap5", 5, 1'b0, 0, 1'b0);
        check("gap5_seq", 64'(last_sent), 64'h0A5A50F0FC);

        set_random_words();
        run_load("poke_start", 0, 1'b1, 0, 1'b0);

        set_random_words();
        run_load("abort10", 0, 1'b0, 10, 1'b0);
        set_random_words();
        run_load("after_abort", 1, 1'b0, 0, 1'b0);

        set_random_words();
        run_load("start_and_abort", 0, 1'b0, 0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            set_random_words();
            run_load($sformatf("rand%0d", r), int'($urandom_range(0, 3)), 1'b0, 0, 1'b0);
        end

        // Reset while shifting
        set_random_words();
        @(negedge config_clock);
        start = 1'b1;
        @(negedge config_clock);
        start      = 1'b0;
        word_valid = 1'b1;
        word_in    = words[0];
        for (int i = 0; i < 20 && !chain_enable; i++) @(negedge config_clock);
        word_valid = 1'b0;
        check("rst_reached_shift", 64'(chain_enable), 64'(1));
        repeat (3) @(negedge config_clock);
        config_nreset = 1'b0;
        #1;
        check("rst_async_enable", 64'(chain_enable), 64'(0));
        check("rst_async_busy", 64'(busy), 64'(0));
        check("rst_async_outs", 64'({word_ready, readback_valid, done, chain_data, readback_word}),
              64'(0));
        @(negedge config_clock);
        config_nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge config_clock);
            check("rst_idle_ready", 64'(word_ready), 64'(0));
            check("rst_idle_busy", 64'(busy), 64'(0));
        end
        $display("reset mid-shift: outputs cleared, idle after release");

        set_random_words();
        run_load("post_reset", 0, 1'b0, 0, 1'b0);
        check("post_reset_rb0", 64'(last_rb.size() > 0 ? last_rb[0] : '1), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
